// File: rtl/ram_access_pkg.sv
// ram_access_pkg: FSM state and RV32I load/store size encodings for ram_access_unit.
package ram_access_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    // Encodings with no load meaning, plus the unsigned codes used with a store.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte/halfword lane extraction with extension, and sub-word store merge.
module mem_lane_align
    import ram_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wword_o
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;
    logic [31:0] hmask;

    // Halfwords select on off_i[1] only; off_i[0] is ignored here.
    assign sh    = {off_i, 3'b000};
    assign b     = word_i[sh +: 8];
    assign h     = off_i[1] ? word_i[31:16] : word_i[15:0];
    assign bmask = 32'h0000_00FF << sh;
    assign hmask = off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;

    always_comb begin
        rdata_o = funct3_i == F3_B  ? {{24{b[7]}}, b}
                : funct3_i == F3_H  ? {{16{h[15]}}, h}
                : funct3_i == F3_W  ? word_i
                : funct3_i == F3_BU ? {24'h0, b}
                : funct3_i == F3_HU ? {16'h0, h}
                : 32'h0;
        wword_o = funct3_i == F3_B ? (word_i & ~bmask) | ({4{wdata_i[7:0]}} & bmask)
                : funct3_i == F3_H ? (word_i & ~hmask) | ({2{wdata_i[15:0]}} & hmask)
                : funct3_i == F3_W ? wdata_i
                : word_i;
    end

endmodule

// File: rtl/ram_access_unit.sv
// ram_access_unit: RV32I load/store engine for an async-read word RAM.
// Define RAM_ACCESS_ALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module ram_access_unit
    import ram_access_pkg::*;
#(
    parameter int W = 32,
    parameter int L = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_addr_i,
    input  logic [W-1:0]         req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [W-1:0]         rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 ram_wr_ena_o,
    output logic [$clog2(L)-1:0] ram_addr_o,
    output logic [W-1:0]         ram_wr_data_o,
    input  logic [W-1:0]         ram_rd_data_i
);

    localparam int AW = $clog2(L);

    state_t        state_q, state_d;
    logic          we_q, err_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [W-1:0]  wdata_q, word_q;
    logic          accept, err_d, misalign;
    logic [W-1:0]  ld_data;

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
    assign misalign = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept = req_valid_i && state_q == IDLE;
    assign err_d  = f3_illegal(req_we_i, req_funct3_i) || req_addr_i >= 32'(4 * L) || misalign;

    always_comb begin
        state_d = state_q == IDLE   ? (!accept ? IDLE
                                      : err_d ? RESP
                                      : (req_we_i && req_funct3_i == F3_W) ? WRITE
                                      : ACCESS)
                : state_q == ACCESS ? (we_q ? WRITE : RESP)
                : state_q == WRITE  ? RESP
                : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we_i;
                err_q   <= err_d;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[AW+1:0];
                wdata_q <= req_wdata_i;
            end
            if (state_q == ACCESS)
                word_q <= ram_rd_data_i;
        end
    end

    mem_lane_align u_align (
        .word_i   (word_q),
        .wdata_i  (wdata_q),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .rdata_o  (ld_data),
        .wword_o  (ram_wr_data_o)
    );

    assign req_ready_o  = state_q == IDLE;
    assign rsp_valid_o  = state_q == RESP;
    assign rsp_err_o    = state_q == RESP && err_q;
    assign rsp_rdata_o  = (state_q == RESP && !err_q && !we_q) ? ld_data : '0;
    // Gating with rst keeps an aborted store out of the RAM on the reset edge.
    assign ram_wr_ena_o = state_q == WRITE && !rst;
    assign ram_addr_o   = addr_q[AW+1:2];

endmodule

// File: doc/ram_access_unit.md
Name: ram_access_unit

Overview:
- Initiator-side load/store engine that drives a single-port, word-addressed, asynchronous-read distributed RAM on behalf of the CPU datapath.
- Accepts RV32I byte-addressed loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready request channel.
- Performs byte-lane extraction, sign extension, and read-modify-write for sub-word stores.
- Returns a single-cycle response pulse.

Parameters:
- W, 32, RAM word width; only 32 is supported.
- L, 128, RAM depth in words. Valid byte addresses are 0 to 4*L-1.

Ports:
- clk  in  1  system clock; everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes are used for SB/SH.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; flags a bad funct3, out-of-range address, or misalignment.
- ram_wr_ena  out  1  RAM write enable.
- ram_addr  out  $clog2(L)  RAM word index, req_addr[$clog2(L)+1:2].
- ram_wr_data  out  32  RAM write data.
- ram_rd_data  in  32  RAM combinational read data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wr_ena=0.
  - Latched request registers and the captured word are cleared to 0.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid&&req_ready: latch we, funct3, addr, wdata.
  - Transitions from IDLE:
    - Error detected at accept: go to RESP with err=1.
    - SW: go to WRITE.
    - Otherwise: go to ACCESS.
- ACCESS:
  - ram_addr = latched index.
  - Register ram_rd_data into word_q.
  - Load: go to RESP. Sub-word store: go to WRITE.
- WRITE:
  - ram_wr_ena=1.
  - ram_wr_data = word_q with the addressed lanes replaced by wdata (SB: lane addr[1:0]; SH: lanes {addr[1],0}/+1; SW: full wdata).
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata: LB/LH sign-extend the selected lane(s); LBU/LHU zero-extend; LW returns the full word.
  - Go to IDLE.
- Latency, counting the handshake edge as cycle 0:
  - Load: rsp_valid in cycle 2.
  - SW: in cycle 2.
  - SB/SH: in cycle 3.
  - Error: in cycle 1.
  - No back-to-back accept: the next handshake occurs no earlier than the cycle after RESP.
- Error conditions (no RAM write occurs):
  - funct3 is 011/110/111.
  - Store with funct3[2]=1.
  - addr >= 4*L.
  - Misalignment (see Optional Feature).
- Outputs outside their states:
  - ram_addr holds the latched index in all states.
  - ram_wr_ena=0 outside WRITE.
- Reset mid-operation:
  - ram_wr_ena is gated with ~rst, so asserting rst while in WRITE suppresses the write on that edge.
  - No rsp_valid pulse is emitted for the aborted request.
- req_* inputs are ignored outside the IDLE handshake. Changing them mid-operation has no effect.

Optional Feature:
- Macro: RAM_ACCESS_ALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is an error: rsp_err=1, no write, rsp_rdata=0.
- Undefined:
  - Halfword accesses use addr[1] only and ignore addr[0].
  - Word accesses ignore addr[1:0].
  - No misalignment error is raised.

Decomposition:
- Package ram_access_pkg contains:
  - state_t enum {IDLE, ACCESS, WRITE, RESP}.
  - funct3_t enum {F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101}.
- One combinational sub-module, mem_lane_align, handles the lane logic:
  - Inputs: word, wdata, addr[1:0], funct3.
  - Outputs: extended load data and merged store word.
  - It is reused by the unit for both the load and store paths.

Test Plan:
- RAM preloaded word0=0x8899AABB. LB addr=0x3 -> rsp_rdata=0xFFFFFF88 in cycle 2, err=0. LBU addr=0x3 -> 0x00000088.
- SB addr=0x1, wdata=0x55 -> one ram_wr_ena pulse in cycle 2; word0 becomes 0x889955BB; rsp_valid in cycle 3.
- SW addr=0x8, wdata=0xDEADBEEF -> ram_wr_ena in cycle 1 only; rsp_valid in cycle 2. A following LH addr=0xA -> 0xFFFFDEAD.
- LW addr=0x200 with L=128 -> rsp_err=1 in cycle 1, rsp_rdata=0, ram_wr_ena never asserted. funct3=3'b011 -> same result.
- With RAM_ACCESS_ALIGN_CHECK_EN defined, SH addr=0x5 -> rsp_err=1 and RAM unchanged. Without it, SH addr=0x5, wdata=0x1234 -> word1 bits[15:0]=0x1234.
- SB accepted, then rst asserted in the WRITE cycle -> no RAM write, no rsp_valid; req_ready=1 on the next cycle.
